// File: rtl/step_debounce.sv
// Step push-button conditioner: sync, debounce FSM, press/release strobes
// and a wrapping press counter, all on the free-running board clock.
module step_debounce #(
  parameter int DEB_CYCLES = 100000,
  parameter int CNT_W      = 17
) (
  input  logic       or_CLK,
  input  logic       Reset,
  input  logic       PB,
  input  logic       Clr,
  output logic       PB_state,
  output logic       PB_down,
  output logic       PB_up,
  output logic [7:0] step_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);

  logic             r_s1;
  logic             r_s2;
  state_t           r_state;
  state_t           w_state_n;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_n;
  logic             w_sync;
  logic             w_last;
  logic             w_press;
  logic             w_release;
  logic             r_pb_state;
  logic             r_pb_down;
  logic             r_pb_up;
  logic [7:0]       r_step_cnt;

  assign w_sync = r_s2;
  assign w_last = (r_cnt == LP_LAST);

  always_ff @(posedge or_CLK or negedge Reset) begin
    if (!Reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= PB;
      r_s2 <= r_s1;
    end
  end

  // cnt falls back to 0 on any state change, so each wait starts fresh
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = '0;
    w_press   = 1'b0;
    w_release = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_sync) w_state_n = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!w_sync) begin
          w_state_n = IDLE;
        end else if (w_last) begin
          w_state_n = HELD;
          w_press   = 1'b1;
        end else begin
          w_cnt_n = r_cnt + LP_ONE;
        end
      end
      HELD: begin
        if (!w_sync) w_state_n = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (w_sync) begin
          w_state_n = HELD;
        end else if (w_last) begin
          w_state_n = IDLE;
          w_release = 1'b1;
        end else begin
          w_cnt_n = r_cnt + LP_ONE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge or_CLK or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
    end
  end

  always_ff @(posedge or_CLK or negedge Reset) begin
    if (!Reset) begin
      r_pb_state <= 1'b0;
      r_pb_down  <= 1'b0;
      r_pb_up    <= 1'b0;
      r_step_cnt <= 8'd0;
    end else begin
      r_pb_down <= w_press;
      r_pb_up   <= w_release;
      if (w_press) begin
        r_pb_state <= 1'b1;
      end else if (w_release) begin
        r_pb_state <= 1'b0;
      end
      // clear has priority over a coincident press
      if (Clr) begin
        r_step_cnt <= 8'd0;
      end else if (w_press) begin
        r_step_cnt <= r_step_cnt + 8'd1;
      end
    end
  end

  assign PB_state = r_pb_state;
  assign PB_down  = r_pb_down;
  assign PB_up    = r_pb_up;
  assign step_cnt = r_step_cnt;

endmodule

// File: tb/tb_step_debounce.sv
// Scoreboard bench for step_debounce with DEB_CYCLES=4: stimulus queues
// expected strobes, a negedge monitor pops and compares them.
module tb_step_debounce;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pb;
  logic       clr;
  logic       pb_state;
  logic       pb_down;
  logic       pb_up;
  logic [7:0] step_cnt;

  typedef struct {
    int kind;
    int cyc;
    int step;
    int lvl;
  } ev_t;

  ev_t        q[$];
  ev_t        m_e;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_step = 8'd0;

  step_debounce #(
    .DEB_CYCLES(4),
    .CNT_W(8)
  ) dut (
    .or_CLK(clk),
    .Reset(rst_n),
    .PB(pb),
    .Clr(clr),
    .PB_state(pb_state),
    .PB_down(pb_down),
    .PB_up(pb_up),
    .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // kind: 1 = press strobe, 2 = release strobe
  always @(negedge clk) begin
    if (pb_down || pb_up) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_strobe: got down=%0d up=%0d at edge %0d, expected none",
                 pb_down, pb_up, cyc);
      end else begin
        m_e = q.pop_front();
        chk("strobe_kind", int'({pb_up, pb_down}), m_e.kind);
        chk("strobe_edge", cyc, m_e.cyc);
        chk("strobe_step_cnt", int'(step_cnt), m_e.step);
        chk("strobe_level", int'(pb_state), m_e.lvl);
      end
    end
  end

  task automatic push(input int k, input int c, input int s, input int l);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.step = s;
    e.lvl  = l;
    q.push_back(e);
  endtask

  task automatic press(input int hold, input int gap);
    int s;
    int r;
    @(negedge clk);
    pb = 1'b1;
    s = cyc + 1;
    exp_step++;
    push(1, s + 6, int'(exp_step), 1);
    repeat (hold) @(negedge clk);
    pb = 1'b0;
    r = cyc + 1;
    push(2, r + 6, int'(exp_step), 0);
    repeat (gap) @(negedge clk);
  endtask

  task automatic bounce(input int hold);
    @(negedge clk);
    pb = 1'b1;
    repeat (hold) @(negedge clk);
    pb = 1'b0;
    repeat (10) @(negedge clk);
    chk("bounce_level", int'(pb_state), 0);
    chk("bounce_step_cnt", int'(step_cnt), int'(exp_step));
  endtask

  initial begin
    int s;
    int r;
    rst_n = 1'b0;
    pb    = 1'b0;
    clr   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_level", int'(pb_state), 0);
    chk("reset_down", int'(pb_down), 0);
    chk("reset_up", int'(pb_up), 0);
    chk("reset_step_cnt", int'(step_cnt), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    bounce(3);
    bounce(4);

    press(20, 12);
    press(5, 12);

    // release bounce restarts the wait
    @(negedge clk);
    pb = 1'b1;
    s = cyc + 1;
    exp_step++;
    push(1, s + 6, int'(exp_step), 1);
    repeat (20) @(negedge clk);
    pb = 1'b0;
    repeat (2) @(negedge clk);
    pb = 1'b1;
    chk("rel_bounce_level", int'(pb_state), 1);
    repeat (2) @(negedge clk);
    pb = 1'b0;
    r = cyc + 1;
    push(2, r + 6, int'(exp_step), 0);
    repeat (3) @(negedge clk);
    chk("rel_restart_level", int'(pb_state), 1);
    repeat (10) @(negedge clk);
    chk("rel_done_level", int'(pb_state), 0);

    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    exp_step = 8'd0;
    chk("clr_alone", int'(step_cnt), 0);

    // clear lands on the same edge as the press increment
    @(negedge clk);
    pb = 1'b1;
    s = cyc + 1;
    exp_step = 8'd0;
    push(1, s + 6, 0, 1);
    repeat (6) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (14) @(negedge clk);
    pb = 1'b0;
    r = cyc + 1;
    push(2, r + 6, 0, 0);
    repeat (10) @(negedge clk);

    for (int i = 0; i < 256; i++) press(6, 8);
    chk("wrap_step_cnt", int'(step_cnt), 0);

    // asynchronous reset while held, then release reset with PB held
    @(negedge clk);
    pb = 1'b1;
    s = cyc + 1;
    exp_step++;
    push(1, s + 6, int'(exp_step), 1);
    repeat (10) @(negedge clk);
    chk("hold_level", int'(pb_state), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_level", int'(pb_state), 0);
    chk("async_rst_step_cnt", int'(step_cnt), 0);
    exp_step = 8'd0;
    repeat (2) @(negedge clk);
    chk("in_rst_up", int'(pb_up), 0);
    rst_n = 1'b1;
    s = cyc + 1;
    exp_step++;
    push(1, s + 6, int'(exp_step), 1);
    repeat (5) @(negedge clk);
    chk("pre_accept_level", int'(pb_state), 0);
    repeat (7) @(negedge clk);
    pb = 1'b0;
    r = cyc + 1;
    push(2, r + 6, int'(exp_step), 0);
    repeat (12) @(negedge clk);

    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/step_debounce.md
# step_debounce

Single-step button conditioner for the single-cycle CPU board build. It sits directly upstream of the CPU top and turns the raw, bouncing step push-button into a clean debounced level, `PB_state`, which drives the CPU's `CLK`. It also produces one-cycle press and release strobes and an 8-bit step counter for the display mux. It runs entirely on the free-running board clock.

## Interface
Parameters:
- `DEB_CYCLES`, default 100000: number of consecutive stable board-clock cycles required to accept a level change. Legal range is 1 to 2^`CNT_W`−1.
- `CNT_W`, default 17: width of the debounce counter.

Ports:
- `or_CLK`  input  1  board clock. One clock; every flop is clocked on the rising edge of `or_CLK`.
- `Reset`  input  1  asynchronous, active-low reset. 0 forces the reset state immediately.
- `PB`  input  1  raw push-button, asynchronous to `or_CLK`. 1 means pressed.
- `Clr`  input  1  synchronous clear of `step_cnt`. Active-high.
- `PB_state`  output  1  debounced button level; feeds CPU `CLK`.
- `PB_down`  output  1  one-cycle strobe on an accepted press.
- `PB_up`  output  1  one-cycle strobe on an accepted release.
- `step_cnt`  output  8  number of accepted presses, wrapping.

## Operation
- **Synchronizer.** `PB` passes through two flops, `s1` then `s2`; `PB_sync` is `s2`. Nothing else samples `PB` directly.
- **Debounce counter.** `cnt` is `CNT_W` bits wide.
  - It loads 0 on every state entry.
  - It increments by 1 each cycle it stays in a WAIT state.
- **State machine, 4 states, encoded state register:**
  - **IDLE** (`PB_state`=0): if `PB_sync`=1, go to PRESS_WAIT and set `cnt`=0.
  - **PRESS_WAIT** (`PB_state`=0):
    - `PB_sync`=0: return to IDLE (bounce rejected).
    - `PB_sync`=1 and `cnt`==`DEB_CYCLES`−1: go to HELD.
    - Otherwise: `cnt`+1.
  - **HELD** (`PB_state`=1): if `PB_sync`=0, go to RELEASE_WAIT and set `cnt`=0.
  - **RELEASE_WAIT** (`PB_state`=1):
    - `PB_sync`=1: return to HELD.
    - `PB_sync`=0 and `cnt`==`DEB_CYCLES`−1: go to IDLE.
    - Otherwise: `cnt`+1.
- **Outputs are registered**, not decoded from the state combinationally.
  - `PB_state` is set on the PRESS_WAIT→HELD edge and cleared on the RELEASE_WAIT→IDLE edge.
  - `PB_down` is 1 for exactly the one cycle after the PRESS_WAIT→HELD transition.
  - `PB_up` is 1 for exactly the one cycle after the RELEASE_WAIT→IDLE transition.
- **Step counter.** `step_cnt` increments on the same edge that sets `PB_down`; 255+1 wraps to 0.
  - `Clr`=1 loads 0.
  - If `Clr`=1 coincides with a press increment, `Clr` wins and the result is 0.
- **Aborted waits.** A bounce that aborts a WAIT state produces no strobe and no `step_cnt` change.
- **Reset** (`Reset`=0, asynchronous):
  - Flops: `s1`=0, `s2`=0, state=IDLE, `cnt`=0.
  - Outputs: `PB_state`=0, `PB_down`=0, `PB_up`=0, `step_cnt`=0.
- **Reset released while `PB` is held:** the block treats it as a fresh press and runs the full debounce sequence.
- **Reset asserted mid-debounce or mid-hold:** the block returns to IDLE at once; no strobe is emitted.

## Timing
- **Press latency.** Let edge S be the first edge at which `s1` samples `PB`=1, with `PB` stable afterwards.
  - `s2`=1 after S+1.
  - The state enters PRESS_WAIT at S+2.
  - HELD is reached and `PB_state`=1, `PB_down`=1 at S+2+`DEB_CYCLES`.
  - `PB_down` returns to 0 at the next edge.
- **Release latency** is symmetric: `PB_state`=0 and `PB_up`=1 at R+2+`DEB_CYCLES`, where R is the edge at which `s1` first samples `PB`=0.
- **Shortest accepted pulse.** A press must be stable for at least `DEB_CYCLES`+1 consecutive `PB_sync` samples to be accepted.
- **Bounce restart.** Any opposite-level sample during a WAIT state restarts the full wait on the next qualifying entry.
- **`DEB_CYCLES`=1:** HELD is reached on the edge after entering PRESS_WAIT.
- **Minimum `PB_state` period.** `PB_state` high and low phases are each at least `DEB_CYCLES`+1 cycles long, so the CPU clock never glitches.

## Test plan
With `DEB_CYCLES`=4:
- **Clean press:** `PB` 0→1 with first sampling edge S, held for 20 cycles → `PB_state`=1 and `PB_down`=1 at S+6; `PB_down`=0 at S+7; `step_cnt`=1.
- **Bounce rejected:** `PB` pulses 1 for 3 cycles then 0 → `PB_state` stays 0, no `PB_down`, `step_cnt` stays 0.
- **Clean release:** after HELD, `PB` 1→0 first sampled at R → `PB_state`=0 and `PB_up`=1 at R+6. A release bounce (`PB` back to 1 for 2 cycles mid-wait) must keep `PB_state`=1 and restart the wait.
- **Counter wrap and clear:** 256 clean presses → `step_cnt`=0 after the last one. `Clr`=1 on the same edge as a `PB_down` increment → `step_cnt`=0.
- **Asynchronous reset mid-hold:** `Reset`=0 between clock edges while in HELD → `PB_state`=0 and `step_cnt`=0 immediately, with no `PB_up`. Releasing `Reset` with `PB` held → `PB_state`=1 exactly 6 edges after the first sampling edge.
